// File: rtl/spi_cfg_sched.sv
// Round-robin arbiter + MSB-first serializer driving per-channel SPI config pins.
// Grant to CS low is 1 cycle; ack pulses CLKDIV*(2*WORD+2)+1 cycles after grant.
// Requests wait while busy; a request is only sampled in IDLE, words only at grant.
module spi_cfg_sched #(
    parameter int NCH    = 4,
    parameter int WORD   = 16,
    parameter int CLKDIV = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WORD-1:0]  req_word,
    output logic [NCH-1:0]       ack,
    output logic                 busy,
    output logic [NCH-1:0]       cs_n,
    output logic [NCH-1:0]       sclk,
    output logic [NCH-1:0]       sdin_o,
    output logic [NCH-1:0]       sdin_t
);

    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = $clog2(WORD + 1);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   half_q, half_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [WORD-1:0] shreg_q, shreg_d, shreg_nxt;
    logic [GW-1:0]   last_q, last_d;
    logic [NCH-1:0]  cs_n_q, cs_n_d, sclk_q, sclk_d;
    logic [NCH-1:0]  sdin_o_q, sdin_o_d, sdin_t_q, sdin_t_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic            busy_q, busy_d;

    logic [GW-1:0]   pick;
    logic            pick_vld;
    logic [WORD-1:0] pick_word;
    logic            half_done;
    logic [WORD-1:0] words [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_words
        assign words[i] = req_word[i*WORD +: WORD];
    end

    assign pick_word = words[pick];

    // Round-robin pick: first set request searching upward from last+1; the
    // loop runs from farthest to nearest so the nearest candidate wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            if (req[GW'((int'(last_q) + k) % NCH)]) begin
                pick     = GW'((int'(last_q) + k) % NCH);
                pick_vld = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; last_q doubles as the active channel.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        last_d    = last_q;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        sdin_o_d  = sdin_o_q;
        sdin_t_d  = sdin_t_q;
        ack_d     = '0;
        half_done = (half_q == HALF_LAST);
        shreg_nxt = shreg_q << 1;

        if (state_q != IDLE) begin
            half_d = half_done ? '0 : half_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d        = SETUP;
                    last_d         = pick;
                    shreg_d        = pick_word;
                    half_d         = '0;
                    bit_d          = '0;
                    cs_n_d[pick]   = 1'b0;
                    sdin_t_d[pick] = 1'b1;
                    sdin_o_d[pick] = pick_word[WORD-1];
                end
            end
            SETUP: begin
                if (half_done) begin
                    state_d        = SHIFT_HI;
                    sclk_d[last_q] = 1'b1;
                end
            end
            SHIFT_HI: begin
                // Falling SCLK: advance to the next bit while the slave holds the last one.
                if (half_done) begin
                    state_d          = SHIFT_LO;
                    sclk_d[last_q]   = 1'b0;
                    shreg_d          = shreg_nxt;
                    sdin_o_d[last_q] = shreg_nxt[WORD-1];
                    bit_d            = bit_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (half_done) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        state_d        = SHIFT_HI;
                        sclk_d[last_q] = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (half_done) begin
                    state_d       = GAP;
                    cs_n_d        = '1;
                    sdin_t_d      = '0;
                    sdin_o_d      = '0;
                    ack_d[last_q] = 1'b1;
                end
            end
            GAP: begin
                if (half_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered pin outputs, synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            half_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            last_q   <= GW'(NCH - 1);
            cs_n_q   <= '1;
            sclk_q   <= '0;
            sdin_o_q <= '0;
            sdin_t_q <= '0;
            ack_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            last_q   <= last_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            sdin_o_q <= sdin_o_d;
            sdin_t_q <= sdin_t_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    assign cs_n   = cs_n_q;
    assign sclk   = sclk_q;
    assign sdin_o = sdin_o_q;
    assign sdin_t = sdin_t_q;
    assign ack    = ack_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_spi_cfg_sched.sv
// Bench for spi_cfg_sched: default instance (a) plus a CLKDIV=2, WORD=8 instance (b).
// Expected (channel, word) pairs are queued at stimulus time and checked on each ack.
// Pin monitors reconstruct the shifted word from rising SCLK and time the CS window.
`timescale 1ns/1ps
module tb_spi_cfg_sched;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [3:0]  req_a, ack_a, cs_n_a, sclk_a, sdin_o_a, sdin_t_a;
    logic [63:0] word_a;
    logic        busy_a;
    logic [3:0]  req_b, ack_b, cs_n_b, sclk_b, sdin_o_b, sdin_t_b;
    logic [31:0] word_b;
    logic        busy_b;

    spi_cfg_sched #(.NCH(4), .WORD(16), .CLKDIV(8)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .req_word(word_a), .ack(ack_a),
        .busy(busy_a), .cs_n(cs_n_a), .sclk(sclk_a), .sdin_o(sdin_o_a), .sdin_t(sdin_t_a)
    );

    spi_cfg_sched #(.NCH(4), .WORD(8), .CLKDIV(2)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .req_word(word_b), .ack(ack_b),
        .busy(busy_b), .cs_n(cs_n_b), .sclk(sclk_b), .sdin_o(sdin_o_b), .sdin_t(sdin_t_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          ch;
        logic [15:0] w;
    } exp_t;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t e_a, e_b;

    logic [3:0]  sclk_pa, cs_pa, sclk_pb, cs_pb;
    logic [15:0] shv_a [4];
    logic [7:0]  shv_b [4];
    int          pul_a [4];
    int          len_a [4];
    int          pul_b [4];
    int          len_b [4];
    int          gap_a, oth_a, tmis_a, tmis_b;
    bit          win_a;

    // Monitor for instance a: bit capture, CS window length, gap, ack scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                shv_a[c] = '0; pul_a[c] = 0; len_a[c] = 0;
            end
            gap_a = 0; win_a = 1'b0; sclk_pa = '0; cs_pa = '1;
        end else begin
            if (ack_a != 4'b0) begin
                if (sb_a.size() == 0) begin
                    chk("a_ack_unexpected", 32'(ack_a), 32'd0);
                end else begin
                    e_a = sb_a.pop_front();
                    oth_a = 0;
                    for (int c = 0; c < 4; c++) if (c != e_a.ch) oth_a += pul_a[c];
                    chk("a_ack_chan", 32'(ack_a), 32'(1) << e_a.ch);
                    chk("a_word", 32'(shv_a[e_a.ch]), 32'(e_a.w));
                    chk("a_cs_low_len", 32'(len_a[e_a.ch]), 32'd272);
                    chk("a_sclk_pulses", 32'(pul_a[e_a.ch]), 32'd16);
                    chk("a_other_pulses", 32'(oth_a), 32'd0);
                    chk("a_cs_high_at_ack", 32'(cs_n_a), 32'hF);
                end
                for (int c = 0; c < 4; c++) begin
                    shv_a[c] = '0; pul_a[c] = 0; len_a[c] = 0;
                end
                gap_a = 0;
                win_a = 1'b1;
            end
            for (int c = 0; c < 4; c++) begin
                if (sclk_a[c] && !sclk_pa[c]) begin
                    shv_a[c] = {shv_a[c][14:0], sdin_o_a[c]};
                    pul_a[c]++;
                end
                if (!cs_n_a[c]) len_a[c]++;
                if (!cs_n_a[c] && cs_pa[c]) begin
                    chk("a_busy_at_cs_fall", 32'(busy_a), 32'd1);
                    if (win_a) chk("a_gap_min", 32'(gap_a >= 9), 32'd1);
                end
            end
            if (&cs_n_a) gap_a++;
            else gap_a = 0;
            if (sdin_t_a !== ~cs_n_a) tmis_a++;
            sclk_pa = sclk_a;
            cs_pa   = cs_n_a;
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (reset) begin
            for (int c = 0; c < 4; c++) begin
                shv_b[c] = '0; pul_b[c] = 0; len_b[c] = 0;
            end
            sclk_pb = '0; cs_pb = '1;
        end else begin
            if (ack_b != 4'b0) begin
                if (sb_b.size() == 0) begin
                    chk("b_ack_unexpected", 32'(ack_b), 32'd0);
                end else begin
                    e_b = sb_b.pop_front();
                    chk("b_ack_chan", 32'(ack_b), 32'(1) << e_b.ch);
                    chk("b_word", 32'(shv_b[e_b.ch]), 32'(e_b.w));
                    chk("b_cs_low_len", 32'(len_b[e_b.ch]), 32'd36);
                    chk("b_sclk_pulses", 32'(pul_b[e_b.ch]), 32'd8);
                end
                for (int c = 0; c < 4; c++) begin
                    shv_b[c] = '0; pul_b[c] = 0; len_b[c] = 0;
                end
            end
            for (int c = 0; c < 4; c++) begin
                if (sclk_b[c] && !sclk_pb[c]) begin
                    shv_b[c] = {shv_b[c][6:0], sdin_o_b[c]};
                    pul_b[c]++;
                end
                if (!cs_n_b[c]) len_b[c]++;
            end
            if (sdin_t_b !== ~cs_n_b) tmis_b++;
            sclk_pb = sclk_b;
            cs_pb   = cs_n_b;
        end
    end

    task automatic wait_ack(input bit inst_b, input int c, input int budget, input bit drop);
        int  n = 0;
        logic hit;
        do begin
            @(negedge clk);
            n++;
            hit = inst_b ? ack_b[c] : ack_a[c];
        end while (!hit && n < budget);
        if (!hit) chk(inst_b ? "b_ack_timeout" : "a_ack_timeout", 32'(hit), 32'd1);
        if (drop) begin
            if (inst_b) req_b[c] = 1'b0;
            else        req_a[c] = 1'b0;
        end
    endtask

    task automatic wait_cs_a(input int c, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cs_n_a[c] && n < budget);
        if (cs_n_a[c]) chk("a_cs_timeout", 32'(cs_n_a[c]), 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "global timeout");
    end

    initial begin
        reset = 1'b1; req_a = '0; req_b = '0; word_a = '0; word_b = '0;
        tmis_a = 0; tmis_b = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n", 32'(cs_n_a), 32'hF);
        chk("rst_sclk", 32'(sclk_a), 32'h0);
        chk("rst_sdin_o", 32'(sdin_o_a), 32'h0);
        chk("rst_sdin_t", 32'(sdin_t_a), 32'h0);
        chk("rst_ack", 32'(ack_a), 32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        chk("rst_b_cs_n", 32'(cs_n_b), 32'hF);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single request on channel 2, plus a short-lived req[1] that must be ignored.
        sb_a.push_back('{2, 16'hA5C3});
        word_a[32 +: 16] = 16'hA5C3;
        req_a[2] = 1'b1;
        wait_cs_a(2, 20);
        repeat (30) @(negedge clk);
        req_a[1] = 1'b1;
        repeat (20) @(negedge clk);
        req_a[1] = 1'b0;
        wait_ack(1'b0, 2, 400, 1'b1);
        repeat (30) @(negedge clk);

        // req[1] dropped at G+50 still completes.
        sb_a.push_back('{1, 16'hFFFF});
        word_a[16 +: 16] = 16'hFFFF;
        req_a[1] = 1'b1;
        wait_cs_a(1, 20);
        repeat (49) @(negedge clk);
        req_a[1] = 1'b0;
        wait_ack(1'b0, 1, 400, 1'b1);
        repeat (20) @(negedge clk);

        // Word changed mid-shift: the value latched at grant goes out.
        sb_a.push_back('{3, 16'h1234});
        word_a[48 +: 16] = 16'h1234;
        req_a[3] = 1'b1;
        wait_cs_a(3, 20);
        repeat (40) @(negedge clk);
        word_a[48 +: 16] = 16'hBEEF;
        wait_ack(1'b0, 3, 400, 1'b1);
        repeat (20) @(negedge clk);

        // All four held high: strict round robin from channel 0.
        word_a = {16'h8001, 16'h7E7E, 16'h0001, 16'hC0DE};
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                sb_a.push_back('{c, word_a[c*16 +: 16]});
        req_a = 4'hF;
        for (int k = 0; k < 8; k++) wait_ack(1'b0, k % 4, 400, 1'b0);
        req_a = 4'h0;
        repeat (20) @(negedge clk);

        // Reset at G+100 of a channel-1 transfer: no ack, priority back to channel 0.
        word_a[16 +: 16] = 16'h3333;
        req_a[1] = 1'b1;
        wait_cs_a(1, 20);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n", 32'(cs_n_a), 32'hF);
        chk("midrst_sclk", 32'(sclk_a), 32'h0);
        chk("midrst_sdin_t", 32'(sdin_t_a), 32'h0);
        chk("midrst_ack", 32'(ack_a), 32'h0);
        chk("midrst_busy", 32'(busy_a), 32'h0);
        req_a = '0;
        @(negedge clk);
        reset = 1'b0;
        sb_a.push_back('{0, 16'hC0DE});
        sb_a.push_back('{3, 16'h8001});
        req_a[0] = 1'b1;
        req_a[3] = 1'b1;
        wait_ack(1'b0, 0, 400, 1'b1);
        wait_ack(1'b0, 3, 400, 1'b1);
        repeat (20) @(negedge clk);

        // Small instance: single request, then two simultaneous (last=1 -> 2 before 0).
        sb_b.push_back('{1, 16'h005A});
        word_b[8 +: 8] = 8'h5A;
        req_b[1] = 1'b1;
        wait_ack(1'b1, 1, 100, 1'b1);
        repeat (10) @(negedge clk);
        word_b[0 +: 8]  = 8'hC3;
        word_b[16 +: 8] = 8'h3C;
        sb_b.push_back('{2, 16'h003C});
        sb_b.push_back('{0, 16'h00C3});
        req_b[0] = 1'b1;
        req_b[2] = 1'b1;
        wait_ack(1'b1, 2, 100, 1'b1);
        wait_ack(1'b1, 0, 100, 1'b1);
        repeat (20) @(negedge clk);

        chk("a_sdin_t_vs_cs_n", 32'(tmis_a), 32'd0);
        chk("b_sdin_t_vs_cs_n", 32'(tmis_b), 32'd0);
        chk("a_sb_leftover", 32'(sb_a.size()), 32'd0);
        chk("b_sb_leftover", 32'(sb_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
